mul32_seq: RTL and testbench



---
 rtl/mul32_seq_if.sv | 21 ++
 rtl/mul32_seq.sv | 143 ++++++++++++++
 tb/tb_mul32_seq.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/mul32_seq_if.sv
// Request/response bundle between the EX-stage pipeline control and the
// sequential 32x32 multiplier.
interface mul32_seq_if;
    logic        start;
    logic        is_signed;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [63:0] p;

    modport master (
        output start, is_signed, a, b,
        input  busy, done, p
    );

    modport slave (
        input  start, is_signed, a, b,
        output busy, done, p
    );
endinterface

// File: rtl/mul32_seq.sv
// Radix-2 shift-add 32x32 multiplier (signed/unsigned) built around a single
// carry-lookahead adder; busy/done handshake toward the pipeline stall logic.
module cla32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        ci,
    output logic [31:0] s
);
    logic [31:0] g_s;
    logic [31:0] p_s;
    logic [31:0] c_s;
    logic        grp_c_s;
    logic        bit_c_s;

    function automatic logic grp_gen(input logic [3:0] g, input logic [3:0] p);
        return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    endfunction

    // 4-bit groups; group carries come from group generate/propagate lookahead
    always_comb begin
        g_s     = a & b;
        p_s     = a ^ b;
        c_s     = 32'd0;
        grp_c_s = ci;
        bit_c_s = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bit_c_s = grp_c_s;
            for (int k = 0; k < 4; k++) begin
                c_s[4*i+k] = bit_c_s;
                bit_c_s    = g_s[4*i+k] | (p_s[4*i+k] & bit_c_s);
            end
            grp_c_s = grp_gen(g_s[4*i +: 4], p_s[4*i +: 4]) | ((&p_s[4*i +: 4]) & grp_c_s);
        end
        s = p_s ^ c_s;
    end
endmodule

module mul32_seq (
    input  logic        clk,
    input  logic        clrn,
    mul32_seq_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        NEG  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic [31:0] mc_r;
    logic [31:0] mq_r;
    logic [31:0] hi_r;
    logic [4:0]  cnt_r;
    logic        neg_r;
    logic [63:0] p_r;
    logic        busy_r;
    logic        done_r;
    logic [31:0] addend_s;
    logic [31:0] sum_s;
    logic        cout_s;

    // 0x80000000 stays 0x80000000 and is then read as unsigned 2^31
    function automatic logic [31:0] mag32(input logic [31:0] x, input logic sgn);
        return (sgn && x[31]) ? (~x + 32'd1) : x;
    endfunction

    assign addend_s = mq_r[0] ? mc_r : 32'd0;

    cla32 u_cla (
        .a  (hi_r),
        .b  (addend_s),
        .ci (1'b0),
        .s  (sum_s)
    );

    assign cout_s = (hi_r[31] & addend_s[31]) | ((hi_r[31] | addend_s[31]) & ~sum_s[31]);

    // Next-state decode
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.start) state_next_s = CALC;
                else           state_next_s = IDLE;
            end
            CALC: begin
                if (cnt_r == 5'd31) state_next_s = neg_r ? NEG : DONE;
                else                state_next_s = CALC;
            end
            NEG:     state_next_s = DONE;
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // State, datapath and registered handshake outputs
    always_ff @(posedge clk) begin
        if (!clrn) begin
            state_r <= IDLE;
            mc_r    <= 32'd0;
            mq_r    <= 32'd0;
            hi_r    <= 32'd0;
            cnt_r   <= 5'd0;
            neg_r   <= 1'b0;
            p_r     <= 64'd0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s != IDLE);
            done_r  <= (state_next_s == DONE);
            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        mc_r  <= mag32(bus.a, bus.is_signed);
                        mq_r  <= mag32(bus.b, bus.is_signed);
                        neg_r <= bus.is_signed & (bus.a[31] ^ bus.b[31]);
                        hi_r  <= 32'd0;
                        cnt_r <= 5'd0;
                    end
                end
                CALC: begin
                    // {hi, mq} <= {cout, s, mq} >> 1; lo accumulates in mq
                    hi_r  <= {cout_s, sum_s[31:1]};
                    mq_r  <= {sum_s[0], mq_r[31:1]};
                    cnt_r <= cnt_r + 5'd1;
                    if (cnt_r == 5'd31 && !neg_r) begin
                        p_r <= {cout_s, sum_s, mq_r[31:1]};
                    end
                end
                NEG:     p_r <= ~{hi_r, mq_r} + 64'd1;
                DONE:    p_r <= p_r;
                default: p_r <= p_r;
            endcase
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.p    = p_r;
endmodule

// File: tb/tb_mul32_seq.sv
// Randomized and directed self-checking bench for mul32_seq against a
// plain-arithmetic product/latency model.
module tb_mul32_seq;
    logic clk;
    logic clrn;
    int   total_cnt;
    int   bad_cnt;
    int   done_cnt;

    mul32_seq_if bus ();

    mul32_seq dut (
        .clk  (clk),
        .clrn (clrn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        if (obs !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        if (sgn) begin
            sa = $signed({{32{a[31]}}, a});
            sb = $signed({{32{b[31]}}, b});
            return sa * sb;
        end else begin
            return {32'd0, a} * {32'd0, b};
        end
    endfunction

    task automatic wait_idle();
        int guard = 0;
        while (bus.busy !== 1'b0 && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        check_eq("idle_wait", {63'd0, bus.busy}, 64'd0);
    endtask

    // inject_at > 0: pulse start with 9x9 after that many iteration cycles
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic sgn, input int inject_at);
        logic [63:0] exp_p;
        logic [63:0] old_p;
        int          exp_lat;
        int          n;
        int          d0;
        logic        hold_ok;
        logic        busy_ok;
        exp_p   = ref_prod(a, b, sgn);
        exp_lat = (sgn && (a[31] ^ b[31])) ? 33 : 32;
        wait_idle();
        @(negedge clk);
        old_p         = bus.p;
        d0            = done_cnt;
        bus.start     = 1'b1;
        bus.a         = a;
        bus.b         = b;
        bus.is_signed = sgn;
        @(posedge clk); #1;
        bus.start     = 1'b0;
        bus.a         = $urandom;
        bus.b         = $urandom;
        bus.is_signed = 1'($urandom_range(0, 1));
        check_eq({tag, "_busy_rise"}, {63'd0, bus.busy}, 64'd1);
        n       = 0;
        hold_ok = 1'b1;
        busy_ok = 1'b1;
        while (n < 40) begin
            @(posedge clk); #1;
            n++;
            if (bus.done === 1'b1) break;
            if (bus.p !== old_p) hold_ok = 1'b0;
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            bus.start = (n == inject_at);
            if (n == inject_at) begin
                bus.a         = 32'd9;
                bus.b         = 32'd9;
                bus.is_signed = 1'b0;
            end
        end
        bus.start = 1'b0;
        check_eq({tag, "_latency"}, 64'(n), 64'(exp_lat));
        check_eq({tag, "_p"}, bus.p, exp_p);
        check_eq({tag, "_hold_busy"}, {62'd0, hold_ok, busy_ok}, 64'd3);
        check_eq({tag, "_busy_at_done"}, {63'd0, bus.busy}, 64'd1);
        @(posedge clk); #1;
        check_eq({tag, "_after_done"}, {62'd0, bus.done, bus.busy}, 64'd0);
        check_eq({tag, "_p_hold"}, bus.p, exp_p);
        check_eq({tag, "_done_pulses"}, 64'(done_cnt - d0), 64'd1);
    endtask

    initial begin
        int d0;
        logic [31:0] ra;
        logic [31:0] rb;
        total_cnt     = 0;
        bad_cnt       = 0;
        done_cnt      = 0;
        clrn          = 1'b0;
        bus.start     = 1'b0;
        bus.is_signed = 1'b0;
        bus.a         = 32'd0;
        bus.b         = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_outputs", {bus.p, 2'b00} | {64'd0, bus.busy, bus.done}, 66'd0);
        @(negedge clk);
        clrn = 1'b1;

        run_op("u7x6",      32'd7,          32'd6,          1'b0, 0);
        run_op("uffxff",    32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 0);
        run_op("s_m3x5",    32'hFFFF_FFFD,  32'd5,          1'b1, 0);
        run_op("s_minxmin", 32'h8000_0000,  32'h8000_0000,  1'b1, 0);
        run_op("s_minx1",   32'h8000_0000,  32'd1,          1'b1, 0);
        run_op("s_0xneg",   32'd0,          32'hFFFF_FFFB,  1'b1, 0);
        run_op("s_negxneg", 32'hFFFF_FFF9,  32'hFFFF_FFFD,  1'b1, 0);

        // request while busy must be dropped, not queued
        run_op("busy_2x3",  32'd2,          32'd3,          1'b0, 10);
        d0 = done_cnt;
        repeat (40) @(posedge clk);
        #1;
        check_eq("no_queued_op", 64'(done_cnt - d0), 64'd0);
        run_op("next_9x9",  32'd9,          32'd9,          1'b0, 0);

        for (int i = 0; i < 16; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 4 == 1) ra[31] = 1'b1;
            run_op("rand", ra, rb, 1'($urandom_range(0, 1)), 0);
        end

        // reset in the middle of an operation discards it
        wait_idle();
        @(negedge clk);
        bus.start     = 1'b1;
        bus.a         = 32'd100;
        bus.b         = 32'd100;
        bus.is_signed = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (14) @(posedge clk);
        @(negedge clk);
        clrn = 1'b0;
        @(posedge clk); #1;
        check_eq("rst_mid_busy_done", {62'd0, bus.busy, bus.done}, 64'd0);
        check_eq("rst_mid_p", bus.p, 64'd0);
        @(negedge clk);
        clrn = 1'b1;
        d0 = done_cnt;
        repeat (40) @(posedge clk);
        #1;
        check_eq("rst_no_done", 64'(done_cnt - d0), 64'd0);
        check_eq("rst_p_stays0", bus.p, 64'd0);
        run_op("after_rst_4x4", 32'd4, 32'd4, 1'b0, 0);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end
endmodule
